// File: rtl/seq_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } seq_state_t;

    localparam logic [8:0] HALT_INSTR  = 9'h1FF;
    localparam int         PC_W_DEF    = 10;
    localparam int         MCODE_W_DEF = 9;

endpackage

// File: rtl/seq_perf_cnt.sv
// Bank of saturating event counters with a shared synchronous clear.
module seq_perf_cnt #(
    parameter int CNT_W   = 16,
    parameter int NUM_CNT = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic [NUM_CNT-1:0]              inc,
    output logic [NUM_CNT-1:0][CNT_W-1:0]   cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (clr)
                    cnt[i] <= '0;
                else if (inc[i] && (cnt[i] != {CNT_W{1'b1}}))
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// FETCH/EXEC/MEM/WB sequencer owning PC and IR; gates write and memory strobes once per instruction.
// Optional SEQ_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int MCODE_W = MCODE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MCODE_W-1:0] rom_data,
    output logic [PC_W-1:0]    pc,
    output logic [MCODE_W-1:0] instr,
    input  logic               branch,
    input  logic               take,
    input  logic [PC_W-1:0]    target,
    input  logic               mem_access,
    input  logic               reg_write,
    output logic               mem_req,
    input  logic               mem_ack,
    output logic               reg_wr_en,
    output logic               busy,
    output logic               done
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]        cycle_cnt,
    output logic [15:0]        instr_cnt
`endif
);

    seq_state_t state, state_nxt;
    logic       idle_or_halt;
    logic       start_ok;
    logic       is_halt;

    assign idle_or_halt = (state == S_IDLE) || (state == S_HALT);
    assign start_ok     = idle_or_halt && start;
    assign is_halt      = (instr == MCODE_W'(HALT_INSTR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC: begin
                if (is_halt)         state_nxt = S_HALT;
                else if (mem_access) state_nxt = S_MEM;
                else                 state_nxt = S_WB;
            end
            S_MEM:   if (mem_ack) state_nxt = S_WB;
            S_WB:    state_nxt = S_FETCH;
            S_HALT:  if (start) state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    // PC wraps naturally at 2^PC_W; a taken branch redirects the very next fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= '0;
        else if (start_ok)
            pc <= '0;
        else if (state == S_WB)
            pc <= (branch && take) ? target : pc + PC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                instr <= '0;
        else if (state == S_FETCH) instr <= rom_data;
    end

    assign mem_req   = (state == S_MEM);
    assign reg_wr_en = (state == S_WB) && reg_write;
    assign busy      = !idle_or_halt;
    assign done      = (state == S_HALT);

`ifdef SEQ_PERF_CNT_EN
    logic [1:0][15:0] perf_cnt;

    seq_perf_cnt #(
        .CNT_W   (16),
        .NUM_CNT (2)
    ) u_perf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .inc   ({state == S_WB, busy}),
        .cnt   (perf_cnt)
    );

    assign cycle_cnt = perf_cnt[0];
    assign instr_cnt = perf_cnt[1];
`endif

endmodule
